// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Captures one frame of offset-binary ADC samples for a single FFT lane.
// The samples are stored as two's complement in a frame RAM. Once the frame
// is full, it is streamed to the FFT core over a valid/ready interface with a
// last marker, and then the loader re-arms for the next window.

module fft_frame_loader #(
    parameter int DATA_W    = 12,
    parameter int OUT_W     = 16,
    parameter int FRAME_LEN = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_input_valid,
    input  logic              write_active,
    output logic [OUT_W-1:0]  m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        FILL,
        LOAD_DONE,
        STREAM
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t             state;
    logic [DATA_W-1:0]  data_d;
    logic               valid_d;
    logic               we;
    logic               handshake;
    logic [OUT_W-1:0]   sample;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [OUT_W-1:0]   mem [FRAME_LEN];

    // Align the ADC strobe with write_active, which the controller registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_d  <= '0;
            valid_d <= 1'b0;
        end else begin
            data_d  <= adc_data;
            valid_d <= adc_input_valid;
        end
    end

    assign we        = valid_d & write_active;
    assign handshake = m_tvalid & m_tready;

    // Offset-binary to two's complement: invert the MSB, then sign-extend.
    assign sample = {{(OUT_W - DATA_W){~data_d[DATA_W-1]}},
                     ~data_d[DATA_W-1], data_d[DATA_W-2:0]};

    // Frame RAM write port. The contents need no reset.
    always_ff @(posedge clk) begin
        if (state == FILL && we) begin
            mem[wr_ptr] <= sample;
        end
    end

    // Control FSM. m_tdata doubles as the RAM read register: rd_ptr always
    // points at the word to prefetch next, and a read is issued only on
    // LOAD_DONE or on a handshake. As a result, a stall holds the word and
    // the loader still delivers one word per cycle under continuous ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (we && state != FILL) begin
                overflow <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (we) begin
                        wr_ptr <= wr_ptr + ADDR_ONE;
                        if (wr_ptr == LAST_ADDR) begin
                            state <= LOAD_DONE;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOAD_DONE: begin
                    m_tdata  <= mem[rd_ptr];
                    m_tlast  <= (rd_ptr == LAST_ADDR);
                    rd_ptr   <= rd_ptr + ADDR_ONE;
                    m_tvalid <= 1'b1;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (handshake) begin
                        if (m_tlast) begin
                            m_tvalid   <= 1'b0;
                            m_tlast    <= 1'b0;
                            frame_done <= 1'b1;
                            rd_ptr     <= '0;
                            busy       <= 1'b0;
                            state      <= FILL;
                        end else begin
                            m_tdata <= mem[rd_ptr];
                            m_tlast <= (rd_ptr == LAST_ADDR);
                            rd_ptr  <= rd_ptr + ADDR_ONE;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
